// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg: shared widths, constants and types for the instruction fetch unit
package rv32_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  typedef enum logic {FETCH_RUN, FETCH_FAULT} fetch_state_e;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of {pc, instr} entries with flush
//   clk, rst        clock, asynchronous active-high reset
//   push_i/pop_i    enqueue wr_data_i / dequeue head (both allowed in one cycle)
//   flush_i         empties the FIFO, overrides push and pop
//   rd_data_o       FIFO head, count_o number of valid entries
module fetch_buffer
  import rv32_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wr_data_i,
  output fetch_entry_t rd_data_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wr_data_i;
        wr_q <= wr_d;
      end
      if (pop_i) rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign rd_data_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF-stage PC generator and fetch buffer for a 1-cycle synchronous imem
//   clk, reset                     clock, asynchronous active-high reset
//   imem_pc / imem_instruction     address to and registered read data from instruction memory
//   if_valid/if_ready/if_pc/if_instruction   valid/ready stream of tagged instructions to IF/ID
//   redirect_valid / redirect_pc   taken branch/jump from EX; flushes wrong-path words
//   fetch_misaligned               only with FETCH_MISALIGN_TRAP_EN: misaligned redirect fault
module instruction_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instruction,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instruction,
  output logic [XLEN-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [XLEN-1:0] issue_pc_q, issue_pc_d, inflight_pc_q;
  logic inflight_valid_q, inflight_valid_d;
  logic pop, push, issue_en, fetch_ok;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head, wr_entry;
`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_e state_q, state_d;
  always_comb state_d = redirect_valid ? ((redirect_pc[1:0] != 2'b00) ? FETCH_FAULT : FETCH_RUN) : state_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH_RUN;
    else state_q <= state_d;
  end
  assign fetch_misaligned = state_q == FETCH_FAULT;
  assign fetch_ok = state_d == FETCH_RUN;
`else
  assign fetch_ok = 1'b1;
`endif
  // occ counts entries the FIFO must still hold after this edge; pop implies count>0 so it never underflows
  always_comb begin
    imem_pc = redirect_valid ? (redirect_pc & ~32'h3) : issue_pc_q;
    if_valid = (count != '0) & ~redirect_valid;
    pop = if_valid & if_ready;
    push = inflight_valid_q & ~redirect_valid;
    occ = {1'b0, count} + (CW+1)'(inflight_valid_q) - (CW+1)'(pop);
    issue_en = occ < (CW+1)'(FIFO_DEPTH);
    inflight_valid_d = (issue_en | redirect_valid) & fetch_ok;
    issue_pc_d = inflight_valid_d ? imem_pc + INSTR_BYTES : issue_pc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_pc_q <= RESET_VECTOR;
      inflight_valid_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      issue_pc_q <= issue_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q <= imem_pc;
    end
  end
  assign wr_entry = '{pc: inflight_pc_q, instr: imem_instruction};
  fetch_buffer #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_buf (
    .clk(clk),
    .rst(reset),
    .push_i(push),
    .pop_i(pop),
    .flush_i(redirect_valid),
    .wr_data_i(wr_entry),
    .rd_data_o(head),
    .count_o(count)
  );
  assign if_pc = head.pc;
  assign if_instruction = head.instr;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for instruction_fetch_unit with a word[k]=k memory model
module tb_instruction_fetch_unit;
  logic clk = 0, reset = 0, if_ready = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic [31:0] imem_pc, imem_instruction, if_instruction, if_pc;
  logic if_valid;
  logic [31:0] w_imem_pc, w_imem_instruction, w_if_instruction, w_if_pc;
  logic w_if_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misaligned, w_fetch_misaligned;
`endif
  int checks = 0, errors = 0;
  logic [31:0] q[$], q_w[$];
  logic [31:0] e, ew;

  always #5 clk = ~clk;
  always @(posedge clk) imem_instruction <= imem_pc >> 2;
  always @(posedge clk) w_imem_instruction <= w_imem_pc >> 2;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instruction(imem_instruction),
    .if_valid(if_valid), .if_ready(if_ready), .if_instruction(if_instruction), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  instruction_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .imem_pc(w_imem_pc), .imem_instruction(w_imem_instruction),
    .if_valid(w_if_valid), .if_ready(1'b1), .if_instruction(w_if_instruction), .if_pc(w_if_pc),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned(w_fetch_misaligned)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got pc %h expected none", if_pc);
      end else begin
        e = q.pop_front();
        chk("pc", if_pc, e);
        chk("instr", if_instruction, e >> 2);
      end
    end
    if (!reset && w_if_valid && q_w.size() != 0) begin
      ew = q_w.pop_front();
      chk("wrap_pc", w_if_pc, ew);
      chk("wrap_instr", w_if_instruction, ew >> 2);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] p);
    int n = 0;
    while (!(if_valid && if_pc == p) && n < 40) begin
      step();
      n++;
    end
    chk("wait_pc", {31'b0, if_valid && if_pc == p}, 32'd1);
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_valid"}, {31'b0, if_valid}, 0);
    chk({tag, "_pc"}, if_pc, 0);
    chk({tag, "_instr"}, if_instruction, 32'h0000_0013);
    chk({tag, "_imem_pc"}, imem_pc, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk({tag, "_misaligned"}, {31'b0, fetch_misaligned}, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    if_ready = 1;
    #2 reset = 1;
    #1 reset_outs("reset");
    for (int i = 0; i <= 16; i += 4) q.push_back(i);
    q_w.push_back(32'hFFFF_FFF8);
    q_w.push_back(32'hFFFF_FFFC);
    q_w.push_back(32'h0000_0000);
    q_w.push_back(32'h0000_0004);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    step();
    chk("first_valid_early", {31'b0, if_valid}, 0);
    step();
    chk("first_valid", {31'b0, if_valid}, 1);
    chk("first_pc", if_pc, 0);
    wait_pc(8);
    if_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'b0, if_valid}, 1);
      chk("stall_pc", if_pc, 8);
    end
    if_ready = 1;
    wait_pc(20);
    if_ready = 0;
    repeat (3) step();
    redirect_valid = 1;
    redirect_pc = 32'h40;
    if_ready = 1;
    q.push_back(32'h40);
    q.push_back(32'h44);
    q.push_back(32'h48);
    #1;
    chk("redir_valid0", {31'b0, if_valid}, 0);
    chk("redir_imem_pc", imem_pc, 32'h40);
    step();
    redirect_valid = 0;
    #1 chk("redir_valid1", {31'b0, if_valid}, 0);
    drain();
    redirect_valid = 1;
    redirect_pc = 32'h80;
    #1 chk("b2b_valid0", {31'b0, if_valid}, 0);
    step();
    redirect_pc = 32'h100;
    q.push_back(32'h100);
    q.push_back(32'h104);
    q.push_back(32'h108);
    #1 chk("b2b_valid1", {31'b0, if_valid}, 0);
    step();
    redirect_valid = 0;
    #1 chk("b2b_valid2", {31'b0, if_valid}, 0);
    drain();
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_valid = 1;
    redirect_pc = 32'h22;
    #1 chk("mis_valid0", {31'b0, if_valid}, 0);
    step();
    redirect_valid = 0;
    chk("mis_flag", {31'b0, fetch_misaligned}, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mis_valid", {31'b0, if_valid}, 0);
      chk("mis_hold", {31'b0, fetch_misaligned}, 1);
    end
    redirect_valid = 1;
    redirect_pc = 32'h20;
    q.push_back(32'h20);
    q.push_back(32'h24);
    step();
    redirect_valid = 0;
    chk("mis_clear", {31'b0, fetch_misaligned}, 0);
    chk("mis_rec_valid0", {31'b0, if_valid}, 0);
    step();
    chk("mis_rec_valid", {31'b0, if_valid}, 1);
    chk("mis_rec_pc", if_pc, 32'h20);
    drain();
    redirect_valid = 1;
    redirect_pc = 32'h22;
    step();
    redirect_valid = 0;
    chk("mis_flag2", {31'b0, fetch_misaligned}, 1);
    if_ready = 0;
    #2 reset = 1;
`else
    if_ready = 0;
    repeat (3) step();
    chk("pre_reset_valid", {31'b0, if_valid}, 1);
    #2 reset = 1;
`endif
    #1 reset_outs("midreset");
    @(negedge clk) reset = 0;
    step();
    chk("post_reset_early", {31'b0, if_valid}, 0);
    step();
    chk("post_reset_valid", {31'b0, if_valid}, 1);
    chk("post_reset_pc", if_pc, 0);
    repeat (2) step();
    chk("queue_empty", q.size(), 0);
    chk("wrap_queue_empty", q_w.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF-stage initiator for the synchronous instruction memory. That memory registers `mem[PC/4]` on every `clk` edge, giving 1-cycle read latency, with no enable and no valid signal.
This block generates the fetch PC, tags each returned word with its PC, and buffers words in a small FIFO. It presents them to IF/ID with a valid/ready handshake and handles branch/jump redirects from EX by flushing wrong-path words.

Parameters:
RESET_VECTOR, 32'h0000_0000, first PC issued after reset
FIFO_DEPTH, 2, entries in fetch buffer (>=2; 2 sustains 1 instr/cycle)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
imem_pc  output  32  address to instruction memory; sampled by memory at each rising edge
imem_instruction  input  32  memory read data; valid the cycle after the edge that sampled imem_pc
if_valid  output  1  if_instruction/if_pc hold a valid correct-path instruction
if_ready  input  1  IF/ID accepts the word this cycle (low = pipeline stall)
if_instruction  output  32  instruction at FIFO head
if_pc  output  32  PC of if_instruction
redirect_valid  input  1  taken branch/jump from EX, single-cycle
redirect_pc  input  32  redirect target

Behaviour:
- State: issue_pc (32), inflight_valid (1), inflight_pc (32), FIFO of {pc, instr}, count (clog2(FIFO_DEPTH+1) bits).
- Reset values: issue_pc = RESET_VECTOR, inflight_valid = 0, count = 0, if_valid = 0, if_instruction = 32'h0000_0013 (NOP), if_pc = 0.
- Defined signals:
  - pop = if_valid & if_ready.
  - issue_en = (count + inflight_valid - pop) < FIFO_DEPTH.
- Addressing:
  - imem_pc = redirect_valid ? {redirect_pc[31:2], 2'b00} : issue_pc (combinational).
  - Memory always reads. A word is kept only if inflight_valid was set for it.
- Each edge:
  - inflight_valid <= issue_en | redirect_valid.
  - inflight_pc <= imem_pc.
  - If issuing, issue_pc <= imem_pc + 4. Otherwise issue_pc holds.
  - Address arithmetic is 32-bit, unsigned; 32'hFFFF_FFFC + 4 wraps to 0.
- Capture: if inflight_valid and no redirect this cycle, push {inflight_pc, imem_instruction} into the FIFO at the edge.
- Output: the FIFO head drives if_pc/if_instruction. if_valid = (count != 0) & ~redirect_valid.
- Latency:
  - First if_valid occurs 2 cycles after reset deasserts (PC = RESET_VECTOR).
  - Redirect penalty is 2 cycles (target word valid 2 edges after the redirect cycle).
- Throughput: 1 instr/cycle with if_ready held high and FIFO_DEPTH = 2.
- Stall: with if_ready low, the FIFO fills, issue stops, and the head is held stable with if_valid high. The in-flight word is never dropped (guaranteed by the issue_en inequality).
- Redirect:
  - Flushes the FIFO (count <= 0) and discards the in-flight word, then issues the target.
  - A pop coinciding with a redirect is ignored; redirect has priority over if_ready.
  - A redirect while the FIFO is full or while in the fault state is legal.
- Back-to-back redirects: the latest wins; the previous target's word is discarded.
- Push and pop in the same cycle: count unchanged, order preserved.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Returned memory data is ignored until the first post-reset issue.
- FSM: RUN, plus FAULT when the optional feature is compiled in. Without the feature only RUN exists.

Optional Feature:
Macro: FETCH_MISALIGN_TRAP_EN.
With the macro:
- Extra port: fetch_misaligned output 1.
- A redirect with redirect_pc[1:0] != 0 moves the FSM RUN -> FAULT. The FIFO and in-flight word are flushed, no further words are kept, and if_valid stays 0.
- fetch_misaligned stays high while in FAULT; reset value is 0.
- An aligned redirect moves FAULT -> RUN and fetches normally.
Without the macro: the low 2 bits of redirect_pc are silently cleared, and there is no fetch_misaligned port.

Decomposition:
- Package rv32_fetch_pkg:
  - XLEN = 32, INSTR_BYTES = 4, NOP_INSTR = 32'h0000_0013.
  - Typedef fetch_entry_t {pc, instr}.
  - FSM state enum {FETCH_RUN, FETCH_FAULT}.
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with push, pop, flush and count. It contains no address logic.

Test Plan:
- Reset release, if_ready = 1, memory preloaded word[k] = k: if_valid first high 2 cycles later with if_pc = 0; then pc 0,4,8,… one per cycle, if_instruction = pc/4.
- Hold if_ready = 0 from the 3rd valid word for 5 cycles: if_pc = 8 held stable, no word lost; on release, the sequence continues 8,12,16 with no gaps and no duplicates.
- redirect_valid with redirect_pc = 32'h40 while the FIFO is full: if_valid = 0 in the redirect cycle and the next cycle. Next valid word has pc 0x40, followed by 0x44; no wrong-path word appears.
- Two consecutive redirect cycles (0x80 then 0x100): only 0x100, 0x104… delivered.
- RESET_VECTOR = 32'hFFFF_FFF8: pcs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- FETCH_MISALIGN_TRAP_EN: redirect to 0x22 -> fetch_misaligned = 1 and if_valid stays 0. Redirect to 0x20 -> fault clears and pc 0x20 is delivered 2 cycles later. Assert reset mid-fault -> all outputs return to reset values immediately.
